// File: rtl/vec_int_ctrl_if.sv
// Handshake bundle between the vectored interrupt controller and the CPU side.
// The block connects to the slave modport; the requester/CPU model drives the master modport.
interface vec_int_ctrl_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] irq;
  logic [N_CH-1:0] mask;
  logic            ien;
  logic            ack;
  logic            eoi;
  logic            i_pending;
  logic [7:0]      vector;
  logic [3:0]      int_id;
  logic [N_CH-1:0] isr;
  logic [N_CH-1:0] ovf;

  modport master (
    output irq, mask, ien, ack, eoi,
    input  i_pending, vector, int_id, isr, ovf
  );

  modport slave (
    input  irq, mask, ien, ack, eoi,
    output i_pending, vector, int_id, isr, ovf
  );
endinterface

// File: rtl/vec_int_ctrl.sv
// Edge-triggered, fixed-priority vectored interrupt controller (lowest channel wins).
// Define INT_NEST_EN to let a higher-priority request preempt a routine already in service.
module vec_int_ctrl #(
  parameter int         N_CH       = 4,
  parameter logic [7:0] VEC_BASE   = 8'h00,
  parameter logic [7:0] VEC_STRIDE = 8'h04
) (
  input  logic          g_clk,
  input  logic          g_clr,
  vec_int_ctrl_if.slave bus
);

  logic [N_CH-1:0] irq_q, irq_d;
  logic [N_CH-1:0] hold_q, hold_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] isr_q, isr_d;
  logic [N_CH-1:0] ovf_q, ovf_d;

  logic [N_CH-1:0] irq_edge;
  logic            cand_vld;
  logic [3:0]      cand_idx;
  logic            isr_any;
  logic [3:0]      isr_low;
  logic            pend_ok;
  logic [3:0]      id_out;
  logic            ack_take;

  function automatic logic [7:0] vec_of(input logic [3:0] id);
    return VEC_BASE + 8'(8'(id) * VEC_STRIDE);
  endfunction

  // hold_q masks lines that were already high while reset was applied, so they
  // do not look like fresh rising edges on the first cycle out of reset.
  assign irq_edge = bus.irq & ~(irq_q | hold_q);

  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    isr_any  = 1'b0;
    isr_low  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (pend_q[k] && bus.mask[k]) begin
        cand_vld = 1'b1;
        cand_idx = 4'(k);
      end
      if (isr_q[k]) begin
        isr_any = 1'b1;
        isr_low = 4'(k);
      end
    end
  end

  always_comb begin
`ifdef INT_NEST_EN
    pend_ok = bus.ien && cand_vld && (!isr_any || (cand_idx < isr_low));
`else
    pend_ok = bus.ien && cand_vld && !isr_any;
`endif
    id_out   = pend_ok ? cand_idx : 4'd0;
    ack_take = bus.ack && pend_ok;
  end

  always_comb begin
    irq_d  = bus.irq;
    hold_d = g_clr ? bus.irq : '0;
    pend_d = pend_q;
    isr_d  = isr_q;
    ovf_d  = ovf_q;
    // A re-request on a pending channel is lost unless the same edge also consumes it.
    for (int k = 0; k < N_CH; k++) begin
      if (irq_edge[k] && pend_q[k] && !(ack_take && (id_out == 4'(k)))) begin
        ovf_d[k] = 1'b1;
      end
    end
    if (ack_take) begin
      pend_d[id_out] = 1'b0;
    end
    pend_d = pend_d | irq_edge;
    // eoi retires the pre-edge highest-priority in-service bit before ack adds its own.
    if (bus.eoi && isr_any) begin
      isr_d[isr_low] = 1'b0;
    end
    if (ack_take) begin
      isr_d[id_out] = 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    hold_q <= hold_d;
    if (g_clr) begin
      irq_q  <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      ovf_q  <= '0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.i_pending = pend_ok;
  assign bus.int_id    = id_out;
  assign bus.vector    = vec_of(id_out);
  assign bus.isr       = isr_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Directed bench for vec_int_ctrl (N_CH=4, VEC_BASE=0, VEC_STRIDE=4) with an expectation queue.
module tb_vec_int_ctrl;

  logic g_clk = 1'b0;
  logic g_clr;

  vec_int_ctrl_if #(.N_CH(4)) bus ();

  vec_int_ctrl #(
    .N_CH      (4),
    .VEC_BASE  (8'h00),
    .VEC_STRIDE(8'h04)
  ) dut (
    .g_clk(g_clk),
    .g_clr(g_clr),
    .bus  (bus.slave)
  );

  always #5 g_clk = ~g_clk;

  typedef struct {
    string      tag;
    logic       ip;
    logic [3:0] id;
    logic [7:0] vec;
    logic [3:0] isr;
    logic [3:0] ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic ip, input logic [3:0] id,
                      input logic [7:0] vec, input logic [3:0] isr, input logic [3:0] ovf);
    exp_t e;
    e.tag = tag; e.ip = ip; e.id = id; e.vec = vec; e.isr = isr; e.ovf = ovf;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      #1;
      cmp(e.tag, "i_pending", {7'd0, bus.i_pending}, {7'd0, e.ip});
      cmp(e.tag, "int_id",    {4'd0, bus.int_id},    {4'd0, e.id});
      cmp(e.tag, "vector",    bus.vector,            e.vec);
      cmp(e.tag, "isr",       {4'd0, bus.isr},       {4'd0, e.isr});
      cmp(e.tag, "ovf",       {4'd0, bus.ovf},       {4'd0, e.ovf});
    end
  endtask

  // Drive one cycle of stimulus, record the expected post-edge outputs, then compare.
  task automatic cyc(input string tag, input logic [3:0] irq_v, input logic ack_v,
                     input logic eoi_v, input logic clr_v,
                     input logic ip, input logic [3:0] id, input logic [7:0] vec,
                     input logic [3:0] isr, input logic [3:0] ovf);
    bus.irq = irq_v;
    bus.ack = ack_v;
    bus.eoi = eoi_v;
    g_clr   = clr_v;
    push(tag, ip, id, vec, isr, ovf);
    @(posedge g_clk);
    #1;
    bus.ack = 1'b0;
    bus.eoi = 1'b0;
    g_clr   = 1'b0;
    pop_check();
  endtask

  task automatic look(input string tag, input logic ip, input logic [3:0] id,
                      input logic [7:0] vec, input logic [3:0] isr, input logic [3:0] ovf);
    push(tag, ip, id, vec, isr, ovf);
    pop_check();
  endtask

  initial begin
    g_clr    = 1'b1;
    bus.irq  = '0;
    bus.mask = 4'hF;
    bus.ien  = 1'b1;
    bus.ack  = 1'b0;
    bus.eoi  = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    g_clr = 1'b0;
    look("reset", 0, 0, 8'h00, 4'h0, 4'h0);
    cyc("ack_idle", 4'b0000, 1, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0);
    cyc("eoi_idle", 4'b0000, 0, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0);

    // Scenario A
    cyc("a_edge", 4'b0100, 0, 0, 0, 1, 2, 8'h08, 4'h0, 4'h0);
    cyc("a_ack",  4'b0100, 1, 0, 0, 0, 0, 8'h00, 4'h4, 4'h0);
    cyc("a_eoi",  4'b0100, 0, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0);

    // Scenario B
    cyc("b_edge", 4'b1010, 0, 0, 0, 1, 1, 8'h04, 4'h0, 4'h0);
    cyc("b_ack1", 4'b1010, 1, 0, 0, 0, 0, 8'h00, 4'h2, 4'h0);
    cyc("b_eoi1", 4'b1010, 0, 1, 0, 1, 3, 8'h0C, 4'h0, 4'h0);
    cyc("b_ack3", 4'b1010, 1, 0, 0, 0, 0, 8'h00, 4'h8, 4'h0);
    cyc("b_eoi3", 4'b0000, 0, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0);

    cyc("cd_edge2", 4'b0100, 0, 0, 0, 1, 2, 8'h08, 4'h0, 4'h0);
    cyc("cd_ack2",  4'b0100, 1, 0, 0, 0, 0, 8'h00, 4'h4, 4'h0);
`ifdef INT_NEST_EN
    // Scenario C
    cyc("c_edge0", 4'b0101, 0, 0, 0, 1, 0, 8'h00, 4'h4, 4'h0);
    cyc("c_ack0",  4'b0101, 1, 0, 0, 0, 0, 8'h00, 4'h5, 4'h0);
    cyc("c_edge3", 4'b1101, 0, 0, 0, 0, 0, 8'h00, 4'h5, 4'h0);
    cyc("c_eoi0",  4'b1101, 0, 1, 0, 0, 0, 8'h00, 4'h4, 4'h0);
    cyc("c_eoi2",  4'b1101, 0, 1, 0, 1, 3, 8'h0C, 4'h0, 4'h0);
    cyc("c_ack3",  4'b1101, 1, 0, 0, 0, 0, 8'h00, 4'h8, 4'h0);
    cyc("c_eoi3",  4'b0000, 0, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0);
`else
    // Scenario D
    cyc("d_edge0", 4'b0101, 0, 0, 0, 0, 0, 8'h00, 4'h4, 4'h0);
    cyc("d_eoi2",  4'b0101, 0, 1, 0, 1, 0, 8'h00, 4'h0, 4'h0);
    cyc("d_ack0",  4'b0101, 1, 0, 0, 0, 0, 8'h00, 4'h1, 4'h0);
    cyc("d_eoi0",  4'b0000, 0, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0);
`endif

    // Masking holds pend; unmasking re-presents. Global enable gates presentation.
    bus.mask = 4'b1110;
    cyc("mask_hold", 4'b0001, 0, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0);
    bus.mask = 4'hF;
    look("unmask", 1, 0, 8'h00, 4'h0, 4'h0);
    bus.ien = 1'b0;
    cyc("ien_off", 4'b0011, 0, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0);
    bus.ien = 1'b1;
    look("ien_on", 1, 0, 8'h00, 4'h0, 4'h0);
    cyc("ack0",  4'b0011, 1, 0, 0, 0, 0, 8'h00, 4'h1, 4'h0);
    cyc("eoi0",  4'b0011, 0, 1, 0, 1, 1, 8'h04, 4'h0, 4'h0);
    cyc("ack1",  4'b0011, 1, 0, 0, 0, 0, 8'h00, 4'h2, 4'h0);
    cyc("eoi1",  4'b0000, 0, 1, 0, 0, 0, 8'h00, 4'h0, 4'h0);

    // Scenario E
    cyc("e_edge1", 4'b0100, 0, 0, 0, 1, 2, 8'h08, 4'h0, 4'h0);
    cyc("e_low",   4'b0000, 0, 0, 0, 1, 2, 8'h08, 4'h0, 4'h0);
    cyc("e_edge2", 4'b0100, 0, 0, 0, 1, 2, 8'h08, 4'h0, 4'h4);
    cyc("e_low2",  4'b0000, 0, 0, 0, 1, 2, 8'h08, 4'h0, 4'h4);
    cyc("e_ackedge", 4'b0100, 1, 0, 0, 0, 0, 8'h00, 4'h4, 4'h4);
    cyc("e_eoi",   4'b0100, 0, 1, 0, 1, 2, 8'h08, 4'h0, 4'h4);

    // Scenario F: pend, isr, ovf all nonzero, then reset with ack and eoi asserted.
    cyc("f_ack",   4'b0000, 1, 0, 0, 0, 0, 8'h00, 4'h4, 4'h4);
    cyc("f_edge",  4'b0100, 0, 0, 0, 0, 0, 8'h00, 4'h4, 4'h4);
    cyc("f_clr",   4'b0100, 1, 1, 1, 0, 0, 8'h00, 4'h0, 4'h0);
    cyc("f_held1", 4'b0100, 0, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0);
    cyc("f_held2", 4'b0100, 0, 0, 0, 0, 0, 8'h00, 4'h0, 4'h0);
    cyc("f_fresh", 4'b0110, 0, 0, 0, 1, 1, 8'h04, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_int_ctrl.md
VEC_INT_CTRL -- requirements
Module: vec_int_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of interrupt channels (legal 2..16).
REQ-002 The block SHALL have parameter VEC_BASE, default 8'h00, giving the vector for channel 0.
REQ-003 The block SHALL have parameter VEC_STRIDE, default 8'h04, giving the vector spacing per channel.
REQ-004 Clocking SHALL be one clock with synchronous, active-high reset, as follows.
REQ-005 g_clk  input  1  clock; all state updates on its rising edge.
REQ-006 g_clr  input  1  synchronous active-high reset (global clear).
REQ-007 irq  input  N_CH  interrupt request lines; edge-sensitive on a rising edge.
REQ-008 mask  input  N_CH  per-channel enable; 1 = channel may be signalled.
REQ-009 ien  input  1  global interrupt enable.
REQ-010 ack  input  1  one-cycle pulse: controller accepts the presented vector.
REQ-011 eoi  input  1  one-cycle pulse: end of the current service routine.
REQ-012 i_pending  output  1  an interrupt is presented to the controller.
REQ-013 vector  output  8  PC target for the presented channel.
REQ-014 int_id  output  4  index of the presented channel.
REQ-015 isr  output  N_CH  in-service bits.
REQ-016 ovf  output  N_CH  sticky lost-request flags.

Function
REQ-017 irq SHALL be registered into irq_q each cycle; edge[k] = irq[k] & ~irq_q[k].
REQ-018 pend[k] SHALL be set at the clock edge where edge[k]=1, so it is visible the following cycle, regardless of mask and ien.
REQ-019 Lowest index SHALL have highest priority; the candidate is the lowest k with pend[k] & mask[k].
REQ-020 i_pending SHALL be combinational and equal to 1 when ien=1, a candidate exists, and the candidate index is lower than every set isr bit (or isr is zero).
REQ-021 When i_pending=1, int_id SHALL equal the candidate index and vector SHALL equal VEC_BASE + int_id*VEC_STRIDE, taken modulo 256; otherwise int_id=0 and vector=VEC_BASE.
REQ-022 On ack with i_pending=1, the block SHALL clear pend[int_id] and set isr[int_id] at that edge.
REQ-023 ack with i_pending=0 SHALL be ignored.
REQ-024 On eoi, the block SHALL clear the lowest-index set isr bit; eoi with isr=0 SHALL be ignored.
REQ-025 If ack and eoi occur in the same cycle, eoi SHALL act on the pre-edge isr, and the ack bit SHALL then be set; both take effect.
REQ-026 If ack and a new edge occur on the same channel in the same cycle, pend SHALL remain 1 (new request wins).
REQ-027 An edge on a channel whose pend is already 1 (and not acked that cycle) SHALL set ovf[k]; ovf SHALL clear only on reset.
REQ-028 Masking a channel SHALL hold its pend bit; unmasking SHALL re-present it.
REQ-029 Channels with index >= N_CH SHALL not exist; int_id SHALL never exceed N_CH-1.

Reset
REQ-030 While g_clr=1 at a clock edge, the block SHALL clear irq_q, pend, isr and ovf to 0.
REQ-031 Following reset, outputs SHALL be i_pending=0, int_id=0, vector=VEC_BASE, isr=0 and ovf=0.
REQ-032 Reset SHALL take priority over ack, eoi and edges in the same cycle.
REQ-033 An irq line held high through reset SHALL not generate an edge after reset.

Configuration
REQ-034 Macro INT_NEST_EN: when defined, the block SHALL allow nested preemption per REQ-020.
REQ-035 When INT_NEST_EN is not defined, i_pending SHALL be 0 whenever isr is nonzero, so isr holds at most one bit, and REQ-025 SHALL reduce to eoi clearing and ack setting that single bit.

Verification
REQ-036 Scenario A: N_CH=4, ien=1, mask=4'hF, rise irq[2], then ack -> i_pending=1 the next cycle with int_id=2 and vector=8'h08; after ack, pend[2]=0 and isr=4'b0100.
REQ-037 Scenario B: rise irq[1] and irq[3] in the same cycle -> int_id=1 and vector=8'h04; after ack and eoi, int_id=3 and vector=8'h0C.
REQ-038 Scenario C (INT_NEST_EN defined): with isr=4'b0100, rise irq[0] and then irq[3] -> irq[0] presented and preempts; irq[3] is not presented until isr=0.
REQ-039 Scenario D (INT_NEST_EN undefined): with isr=4'b0100, rise irq[0] -> i_pending=0 until eoi, then int_id=0.
REQ-040 Scenario E: two irq[2] edges without ack -> ovf=4'b0100; ack and edge in the same cycle -> pend[2]=1 and ovf unchanged.
REQ-041 Scenario F: assert g_clr with pend, isr and ovf nonzero and ack=1 -> all zero the next cycle and vector=VEC_BASE.
